imem_loader: RTL and testbench
==============================

// Module: imem_loader
// PURPOSE
//  Write-side counterpart of the instruction memory. Receives a program as a
//  byte stream (valid/ready) and assembles little-endian 32-bit words.
//  Writes each word into the instruction memory write port at consecutive
//  byte addresses, starting at 0x0.
//  Holds the core in reset while loading, then releases it.
// PARAMETERS
//  DEPTH   32  instruction memory depth in words (max loadable words)
//  LW       6  width of len_words; must hold DEPTH (clog2(DEPTH)+1)
// PORTS
//  clk        in   1   system clock, all state on rising edge
//  rst        in   1   asynchronous, active-low reset
//  start      in   1   1-cycle request to begin a load; sampled in IDLE only
//  len_words  in   LW  word count to load; latched when start accepted
//  in_data    in   8   program byte, lowest-addressed byte first
//  in_valid   in   1   in_data valid
//  in_ready   out  1   loader accepts byte; transfer = in_valid & in_ready
//  abort      in   1   cancel load in progress
//  we         out  1   imem write enable, 1-cycle pulse per word
//  waddr      out  32  imem byte address = word_index<<2 (bits[1:0]=0)
//  wdata      out  32  assembled word {b3,b2,b1,b0}
//  busy       out  1   1 in RECV/WRITE
//  done       out  1   1-cycle pulse when a load completes successfully
//  err        out  1   sticky: start with len_words>DEPTH; cleared by next accepted start
//  cpu_rst    out  1   active-low core reset = rst & (state==IDLE)
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, in_ready=0, we=0, waddr=0, wdata=0,
//   busy=0, done=0, err=0, byte_cnt=0, word_cnt=0; cpu_rst=0 while rst=0.
//  States: IDLE, RECV, WRITE, DONE.
//  IDLE: start=1 & 0<len_words<=DEPTH -> latch len, clear counters and err,
//   go RECV. start=1 & len_words==0 -> DONE (no writes).
//   start=1 & len_words>DEPTH -> err=1, stay IDLE.
//  RECV: in_ready=1. Each transfer stores in_data into byte lane byte_cnt;
//   byte_cnt increments 0..3. Transfer at byte_cnt==3 -> WRITE next cycle.
//  WRITE: in_ready=0, we=1 for exactly one cycle;
//   waddr={word_cnt,2'b00}, wdata=assembled word.
//   If word_cnt==len-1 -> DONE, else word_cnt+1 -> RECV.
//  Latency: 4th byte accepted at edge N -> we high in cycle N+1.
//   Minimum 5 cycles per word.
//  DONE: done=1 for one cycle -> IDLE; cpu_rst rises with entry to IDLE.
//  in_valid=0 in RECV: stall indefinitely; partial word retained.
//  abort=1 in RECV/WRITE/DONE: -> IDLE next edge, we=0, no done pulse.
//   Words already written stay in memory; partial word discarded.
//   abort has priority over a coincident write.
//  start ignored outside IDLE; abort in IDLE has no effect.
//  waddr never exceeds (DEPTH-1)<<2; word_cnt never wraps.
//  cpu_rst is low from accepted start through the DONE cycle.
// TESTING
//  Reset mid-load: rst=0 during RECV byte 2 -> all outputs reset at once,
//   no we; after release, cpu_rst=1 and state=IDLE.
//  Load 2 words, bytes 13,01,50,00,93,01,C0,00 -> we@waddr 0x0 wdata
//   0x00500113, then we@0x4 wdata 0x00C00193; one done pulse;
//   cpu_rst low throughout.
//  Stalls: in_valid toggled 1/0 every cycle, len=1, bytes B3,82,42,00 ->
//   single we with wdata 0x004282B3, no extra or early write.
//  Full depth: len=32, 128 bytes -> 32 writes, last waddr 0x7C, done;
//   len=33 -> err=1, no we, cpu_rst stays 1.
//  Abort after 6 bytes, len=3 -> exactly one write (addr 0x0), no done,
//   IDLE next cycle; a new start then loads from addr 0x0.
//  len=0 start -> done pulse 1 cycle later, no we; start during busy ignored.

Source files
------------

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
// Loader-side signals on the slave modport; the stream source/memory model uses master.
interface imem_loader_if;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        we;
  logic [31:0] waddr;
  logic [31:0] wdata;

  modport master (
    output in_data, in_valid,
    input  in_ready, we, waddr, wdata
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, we, waddr, wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Assembles a little-endian byte stream into 32-bit imem writes at 0x0, 0x4, ... while holding the core in reset.
// Latency: we 1 cycle after the 4th byte of a word; in_valid low stalls RECV with the partial word held.
module imem_loader #(
  parameter int DEPTH = 32,
  parameter int LW    = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [LW-1:0] len_words,
  input  logic          abort,
  imem_loader_if.slave  bus,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          cpu_rst
);

  typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

  state_t        state;
  logic [LW-1:0] len;
  logic [LW-1:0] word_cnt;
  logic [1:0]    byte_cnt;
  logic [31:0]   word_buf;

  assign cpu_rst = rst & (state == IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      len          <= '0;
      word_cnt     <= '0;
      byte_cnt     <= '0;
      word_buf     <= '0;
      bus.in_ready <= 1'b0;
      bus.we       <= 1'b0;
      bus.waddr    <= '0;
      bus.wdata    <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      bus.we <= 1'b0;
      done   <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (len_words > DEPTH_L) begin
              err <= 1'b1;
            end else if (len_words == '0) begin
              err   <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              err          <= 1'b0;
              len          <= len_words;
              word_cnt     <= '0;
              byte_cnt     <= '0;
              bus.in_ready <= 1'b1;
              busy         <= 1'b1;
              state        <= RECV;
            end
          end
        end
        RECV: begin
          if (abort) begin
            bus.in_ready <= 1'b0;
            busy         <= 1'b0;
            state        <= IDLE;
          end else if (bus.in_valid) begin
            word_buf[{byte_cnt, 3'b000} +: 8] <= bus.in_data;
            byte_cnt <= byte_cnt + 2'd1;
            // The last byte goes straight into wdata so we can pulse next cycle.
            if (byte_cnt == 2'd3) begin
              bus.in_ready <= 1'b0;
              bus.we       <= 1'b1;
              bus.waddr    <= 32'({word_cnt, 2'b00});
              bus.wdata    <= {bus.in_data, word_buf[23:0]};
              state        <= WRITE;
            end
          end
        end
        WRITE: begin
          if (abort) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else if (word_cnt == len - LW'(1)) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            word_cnt     <= word_cnt + LW'(1);
            bus.in_ready <= 1'b1;
            state        <= RECV;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Drives random and directed programs into imem_loader and compares captured writes to a byte-queue model.
module tb_imem_loader;
  localparam int DEPTH = 32;
  localparam int LW    = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [LW-1:0] len_words;
  logic          abort;
  logic          busy, done, err, cpu_rst;

  imem_loader_if bus ();

  imem_loader #(.DEPTH(DEPTH), .LW(LW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .len_words (len_words),
    .abort     (abort),
    .bus       (bus),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .cpu_rst   (cpu_rst)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] cap_addr[$];
  logic [31:0] cap_data[$];
  logic [7:0]  bq[$];
  int          done_cnt = 0;
  int          cpu_rst_bad = 0;

  // Memory-side observer: values read here are the ones held during the cycle just ending.
  always @(posedge clk) begin
    if (rst === 1'b1) begin
      if (bus.we === 1'b1) begin
        cap_addr.push_back(bus.waddr);
        cap_data.push_back(bus.wdata);
      end
      if (done === 1'b1) done_cnt++;
      if (busy === 1'b1 && cpu_rst !== 1'b0) cpu_rst_bad++;
    end
  end

  function automatic logic [31:0] exp_word(input int i);
    return {bq[4*i+3], bq[4*i+2], bq[4*i+1], bq[4*i]};
  endfunction

  task automatic fill_bq(input int nwords);
    bq.delete();
    for (int i = 0; i < 4*nwords; i++) bq.push_back(8'($urandom));
  endtask

  task automatic do_start(input int len);
    start = 1'b1;
    len_words = LW'(len);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, output bit ok);
    logic r;
    ok = 1'b0;
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    for (int n = 0; n < 50; n++) begin
      r = bus.in_ready;
      @(negedge clk);
      if (r) begin
        ok = 1'b1;
        break;
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic send_range(input int first, input int last, input int gap, output bit ok);
    bit o;
    ok = 1'b1;
    for (int i = first; i <= last; i++) begin
      send_byte(bq[i], o);
      if (!o) ok = 1'b0;
      if (gap > 0) repeat ($urandom_range(gap, 0)) @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst = 1'b0; start = 1'b0; abort = 1'b0; len_words = '0;
    bus.in_valid = 1'b0; bus.in_data = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.in_ready, bus.we, busy, done, err, cpu_rst} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 000000", {bus.in_ready, bus.we, busy, done, err, cpu_rst});
    end
    checks++;
    if (bus.waddr !== 32'h0 || bus.wdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_bus: got waddr=%h wdata=%h expected 0/0", bus.waddr, bus.wdata);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (cpu_rst !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got cpu_rst=%b busy=%b expected 1/0", cpu_rst, busy);
    end
  endtask

  task automatic test_two_words;
    bit ok;
    int d0;
    cap_addr.delete(); cap_data.delete();
    bq = '{8'h13, 8'h01, 8'h50, 8'h00, 8'h93, 8'h01, 8'hC0, 8'h00};
    d0 = done_cnt;
    do_start(2);
    checks++;
    if (busy !== 1'b1 || cpu_rst !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL two_start: got busy=%b cpu_rst=%b in_ready=%b expected 1/0/1", busy, cpu_rst, bus.in_ready);
    end
    send_range(0, 3, 0, ok);
    checks++;
    if (!ok || bus.we !== 1'b1 || bus.waddr !== 32'h0 || bus.wdata !== 32'h00500113) begin
      errors++;
      $display("FAIL two_word0: got ok=%0d we=%b waddr=%h wdata=%h expected 1/1/0/00500113", ok, bus.we, bus.waddr, bus.wdata);
    end
    send_range(4, 7, 0, ok);
    checks++;
    if (!ok || bus.we !== 1'b1 || bus.waddr !== 32'h4 || bus.wdata !== 32'h00C00193) begin
      errors++;
      $display("FAIL two_word1: got ok=%0d we=%b waddr=%h wdata=%h expected 1/1/4/00c00193", ok, bus.we, bus.waddr, bus.wdata);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || cpu_rst !== 1'b0 || bus.we !== 1'b0) begin
      errors++;
      $display("FAIL two_done: got done=%b cpu_rst=%b we=%b expected 1/0/0", done, cpu_rst, bus.we);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || cpu_rst !== 1'b1 || cap_data.size() != 2 || done_cnt != d0 + 1) begin
      errors++;
      $display("FAIL two_after: got done=%b cpu_rst=%b writes=%0d dones=%0d expected 0/1/2/1", done, cpu_rst, cap_data.size(), done_cnt - d0);
    end
  endtask

  task automatic test_stall;
    bit ok, o;
    cap_addr.delete(); cap_data.delete();
    bq = '{8'hB3, 8'h82, 8'h42, 8'h00};
    do_start(1);
    ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send_byte(bq[i], o);
      if (!o) ok = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (!ok || bus.we !== 1'b0 || cap_data.size() != 0) begin
      errors++;
      $display("FAIL stall_early: got ok=%0d we=%b writes=%0d expected 1/0/0", ok, bus.we, cap_data.size());
    end
    send_byte(bq[3], o);
    checks++;
    if (!o || bus.we !== 1'b1 || bus.wdata !== 32'h004282B3) begin
      errors++;
      $display("FAIL stall_word: got ok=%0d we=%b wdata=%h expected 1/1/004282b3", o, bus.we, bus.wdata);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (cap_data.size() != 1) begin
      errors++;
      $display("FAIL stall_count: got %0d writes expected 1", cap_data.size());
    end
  endtask

  task automatic test_full_depth;
    bit ok;
    int d0, bad;
    cap_addr.delete(); cap_data.delete();
    fill_bq(DEPTH);
    d0 = done_cnt;
    do_start(DEPTH);
    send_range(0, 4*DEPTH-1, 0, ok);
    @(negedge clk);
    checks++;
    if (!ok || done !== 1'b1) begin
      errors++;
      $display("FAIL full_done: got ok=%0d done=%b expected 1/1", ok, done);
    end
    @(negedge clk);
    bad = 0;
    if (cap_data.size() == DEPTH) begin
      for (int i = 0; i < DEPTH; i++)
        if (cap_addr[i] !== 32'(4*i) || cap_data[i] !== exp_word(i)) bad++;
    end
    checks++;
    if (cap_data.size() != DEPTH || bad != 0 || cap_addr[cap_addr.size()-1] !== 32'h7C || done_cnt != d0 + 1) begin
      errors++;
      $display("FAIL full_writes: got writes=%0d bad=%0d dones=%0d expected 32/0/1 last addr 7c", cap_data.size(), bad, done_cnt - d0);
    end
    cap_addr.delete(); cap_data.delete();
    do_start(DEPTH + 1);
    checks++;
    if (err !== 1'b1 || busy !== 1'b0 || bus.in_ready !== 1'b0 || cpu_rst !== 1'b1) begin
      errors++;
      $display("FAIL over_len: got err=%b busy=%b in_ready=%b cpu_rst=%b expected 1/0/0/1", err, busy, bus.in_ready, cpu_rst);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (err !== 1'b1 || cap_data.size() != 0 || cpu_rst !== 1'b1) begin
      errors++;
      $display("FAIL over_sticky: got err=%b writes=%0d cpu_rst=%b expected 1/0/1", err, cap_data.size(), cpu_rst);
    end
    fill_bq(1);
    do_start(1);
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL err_clear: got err=%b expected 0", err);
    end
    send_range(0, 3, 0, ok);
    repeat (2) @(negedge clk);
  endtask

  task automatic test_abort;
    bit ok;
    int d0;
    cap_addr.delete(); cap_data.delete();
    fill_bq(3);
    d0 = done_cnt;
    do_start(3);
    send_range(0, 5, 0, ok);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if (!ok || busy !== 1'b0 || bus.in_ready !== 1'b0 || cpu_rst !== 1'b1) begin
      errors++;
      $display("FAIL abort_idle: got ok=%0d busy=%b in_ready=%b cpu_rst=%b expected 1/0/0/1", ok, busy, bus.in_ready, cpu_rst);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (cap_data.size() != 1 || cap_addr[0] !== 32'h0 || cap_data[0] !== exp_word(0) || done_cnt != d0) begin
      errors++;
      $display("FAIL abort_writes: got writes=%0d dones=%0d expected 1 write at 0 data %h, 0 dones", cap_data.size(), done_cnt - d0, exp_word(0));
    end
    cap_addr.delete(); cap_data.delete();
    fill_bq(1);
    do_start(1);
    send_range(0, 3, 0, ok);
    repeat (2) @(negedge clk);
    checks++;
    if (!ok || cap_data.size() != 1 || cap_addr[0] !== 32'h0 || cap_data[0] !== exp_word(0)) begin
      errors++;
      $display("FAIL abort_reload: got writes=%0d addr=%h data=%h expected 1/0/%h", cap_data.size(), cap_addr[0], cap_data[0], exp_word(0));
    end
  endtask

  task automatic test_len0_and_ignore;
    bit ok;
    int d0;
    cap_addr.delete(); cap_data.delete();
    d0 = done_cnt;
    do_start(0);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || cpu_rst !== 1'b0) begin
      errors++;
      $display("FAIL len0_done: got done=%b busy=%b cpu_rst=%b expected 1/0/0", done, busy, cpu_rst);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (done !== 1'b0 || cap_data.size() != 0 || done_cnt != d0 + 1 || cpu_rst !== 1'b1) begin
      errors++;
      $display("FAIL len0_after: got done=%b writes=%0d dones=%0d cpu_rst=%b expected 0/0/1/1", done, cap_data.size(), done_cnt - d0, cpu_rst);
    end
    fill_bq(2);
    do_start(2);
    send_range(0, 0, 0, ok);
    do_start(1);
    send_range(1, 7, 0, ok);
    repeat (2) @(negedge clk);
    checks++;
    if (!ok || cap_data.size() != 2 || cap_data[0] !== exp_word(0) || cap_data[1] !== exp_word(1)) begin
      errors++;
      $display("FAIL busy_start: got ok=%0d writes=%0d expected 2 words %h %h", ok, cap_data.size(), exp_word(0), exp_word(1));
    end
  endtask

  task automatic test_reset_mid_load;
    bit ok;
    cap_addr.delete(); cap_data.delete();
    fill_bq(2);
    do_start(2);
    send_range(0, 1, 0, ok);
    rst = 1'b0;
    #1;
    checks++;
    if ({bus.in_ready, bus.we, busy, done, err, cpu_rst} !== 6'b0) begin
      errors++;
      $display("FAIL midrst_async: got %b expected 000000", {bus.in_ready, bus.we, busy, done, err, cpu_rst});
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (cpu_rst !== 1'b1 || busy !== 1'b0 || cap_data.size() != 0) begin
      errors++;
      $display("FAIL midrst_release: got cpu_rst=%b busy=%b writes=%0d expected 1/0/0", cpu_rst, busy, cap_data.size());
    end
    fill_bq(1);
    do_start(1);
    send_range(0, 3, 0, ok);
    repeat (2) @(negedge clk);
    checks++;
    if (!ok || cap_data.size() != 1 || cap_addr[0] !== 32'h0 || cap_data[0] !== exp_word(0)) begin
      errors++;
      $display("FAIL midrst_reload: got writes=%0d data=%h expected 1 write %h at 0", cap_data.size(), cap_data[0], exp_word(0));
    end
  endtask

  task automatic test_random;
    bit ok;
    int len, d0, bad;
    for (int it = 0; it < 6; it++) begin
      cap_addr.delete(); cap_data.delete();
      len = $urandom_range(6, 1);
      fill_bq(len);
      d0 = done_cnt;
      do_start(len);
      send_range(0, 4*len-1, 2, ok);
      repeat (4) @(negedge clk);
      bad = 0;
      if (cap_data.size() == len) begin
        for (int i = 0; i < len; i++)
          if (cap_addr[i] !== 32'(4*i) || cap_data[i] !== exp_word(i)) bad++;
      end
      checks++;
      if (!ok || cap_data.size() != len || bad != 0 || done_cnt != d0 + 1) begin
        errors++;
        $display("FAIL random_%0d: got ok=%0d writes=%0d bad=%0d dones=%0d expected 1/%0d/0/1", it, ok, cap_data.size(), bad, done_cnt - d0, len);
      end
    end
    checks++;
    if (cpu_rst_bad != 0) begin
      errors++;
      $display("FAIL cpu_rst_hold: got %0d busy cycles with cpu_rst high expected 0", cpu_rst_bad);
    end
  endtask

  initial begin
    test_reset();
    test_two_words();
    test_stall();
    test_full_depth();
    test_abort();
    test_len0_and_ignore();
    test_reset_mid_load();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
